pulse_meter: RTL and testbench
==============================

Name: pulse_meter

Overview:
- Downstream consumer of the pulse generator stage: samples its single-bit pulse output on the system clock.
- Measures high width, low width and period of every complete pulse, in clock cycles.
- Counts completed periods.
- Presents latched results with a one-cycle valid strobe, for a display or checker stage to consume.

Parameters:
- W, 8, width of the width/period counters and of the result outputs.
- CW, 16, width of the completed-pulse counter.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- signal  input  1  pulse stream from the upstream pulse generator.
- high_width  output  W  cycles the last complete pulse was high.
- low_width  output  W  cycles the last complete pulse was low.
- period  output  W  high_width+low_width of the last pulse, saturating.
- valid  output  1  one-cycle strobe: the result outputs were updated this cycle.
- pulse_count  output  CW  completed periods since reset; wraps modulo 2^CW.
- overflow  output  1  sticky: a width counter saturated.
- busy  output  1  high in HIGH or LOW state.

Behaviour:
- Reset is sampled at the clock edge; while reset==0 after the edge:
  - state=IDLE, prev=0, both counters=0.
  - high_width=low_width=period=0, valid=0, pulse_count=0, overflow=0, busy=0.
- Sampling:
  - s = signal (or its synchronized copy, see Optional Feature); prev <= s every cycle.
  - rise = s & ~prev; fall = ~s & prev.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for rise. On rise: go to HIGH, hcnt<=1, lcnt<=0. A level already high out of reset is not a rise.
  - HIGH: hcnt increments each cycle s==1. On fall: go to LOW, lcnt<=1.
  - LOW: lcnt increments each cycle s==0. On rise, in the same edge:
    - high_width<=hcnt, low_width<=lcnt, period<=sat(hcnt+lcnt).
    - valid<=1, pulse_count<=pulse_count+1.
    - hcnt<=1, lcnt<=0, state stays HIGH (back-to-back measurement, no idle gap).
- Latency: valid rises on the edge after the first high sample of the next pulse, i.e. one edge after rise is sampled. valid is 0 on all other cycles.
- Arithmetic:
  - hcnt and lcnt saturate at 2^W-1; on reaching saturation, overflow<=1 and stays 1 until reset.
  - period is computed in W+1 bits and clamped to 2^W-1.
  - pulse_count wraps 2^CW-1 -> 0 without flagging.
- Boundary cases:
  - A 1-cycle high or 1-cycle low is legal and measures 1.
  - A constant input in HIGH or LOW saturates the counter: no valid, state held until the next edge.
  - Reset asserted mid-measurement discards the partial pulse; the first period after reset starts from IDLE.
- Result outputs hold their value between valid strobes.
- busy = (state != IDLE).

Optional Feature:
- Macro: PULSE_METER_SYNC_EN.
- Defined:
  - signal passes through a 2-flop synchronizer before sampling; both flops are reset to 0.
  - All edge detection and valid timing shift 2 cycles later; measured widths are unchanged.
- Undefined:
  - signal is used directly as s, assumed synchronous to clock.
  - No extra latency.

Test Plan:
- Reset held low 3 cycles with signal toggling -> all outputs 0, busy=0, no valid.
- signal toggles every cycle for 10 cycles -> each valid: high_width=1, low_width=1, period=2; pulse_count increments by 1 per strobe.
- signal high 3 cycles, low 5 cycles, repeated 4 times -> high_width=3, low_width=5, period=8, pulse_count=3 after the fourth rise, valid exactly once per rise after the first.
- W=4, signal high 20 cycles then low 2 then high -> high_width=15, low_width=2, period=15 (clamped), overflow=1 and remains 1 afterwards.
- Reset pulsed low for 1 cycle during a high phase, then 2-high/2-low pattern -> no valid for the interrupted pulse; first valid reports 2/2/4, pulse_count=1.
- With PULSE_METER_SYNC_EN defined, repeat the 3/5 pattern -> same widths; each valid occurs 2 cycles later than in the undefined build.

Source files
------------

// File: rtl/pulse_meter.sv
// pulse_meter: measures high width, low width and period of a single-bit
// pulse stream, counts completed periods and presents latched results with
// a one-cycle valid strobe.
// Optional feature macro: PULSE_METER_SYNC_EN (2-flop input synchronizer).
module pulse_meter #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          signal,
    output logic [W-1:0]  high_width,
    output logic [W-1:0]  low_width,
    output logic [W-1:0]  period,
    output logic          valid,
    output logic [CW-1:0] pulse_count,
    output logic          overflow,
    output logic          busy
);

    localparam logic [W-1:0] MAX      = {W{1'b1}};
    localparam logic [W-1:0] NEAR_MAX = {{(W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic         s, prev, armed, rise, fall;
    logic [W-1:0] hcnt, lcnt, hcnt_nxt, lcnt_nxt;
    logic         latch, sat_hit;
    logic [W:0]   sum;
    logic [W-1:0] period_sat;

`ifdef PULSE_METER_SYNC_EN
    logic sync1, sync2;

    // Two-flop synchronizer ahead of edge detection
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= signal;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = signal;
`endif

    assign rise = s & ~prev;
    assign fall = ~s & prev;

    // Period of the pulse being closed, clamped to the result width
    assign sum        = {1'b0, hcnt} + {1'b0, lcnt};
    assign period_sat = sum[W] ? MAX : sum[W-1:0];

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, counter updates and result-latch request
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        lcnt_nxt  = lcnt;
        latch     = 1'b0;
        sat_hit   = 1'b0;
        case (state)
            IDLE: begin
                // armed: a low has been seen since reset, so a level that is
                // already high out of reset never counts as a rise
                if (rise && armed) begin
                    state_nxt = HIGH;
                    hcnt_nxt  = W'(1);
                    lcnt_nxt  = '0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_nxt = LOW;
                    lcnt_nxt  = W'(1);
                end else if (s && hcnt != MAX) begin
                    hcnt_nxt = hcnt + W'(1);
                    sat_hit  = (hcnt == NEAR_MAX);
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt = HIGH;
                    latch     = 1'b1;
                    hcnt_nxt  = W'(1);
                    lcnt_nxt  = '0;
                end else if (!s && lcnt != MAX) begin
                    lcnt_nxt = lcnt + W'(1);
                    sat_hit  = (lcnt == NEAR_MAX);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sampling, counters and registered result outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            prev        <= 1'b0;
            armed       <= 1'b0;
            hcnt        <= '0;
            lcnt        <= '0;
            high_width  <= '0;
            low_width   <= '0;
            period      <= '0;
            valid       <= 1'b0;
            pulse_count <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            prev     <= s;
            armed    <= armed | ~s;
            hcnt     <= hcnt_nxt;
            lcnt     <= lcnt_nxt;
            valid    <= latch;
            overflow <= overflow | sat_hit;
            busy     <= (state_nxt != IDLE);
            if (latch) begin
                high_width  <= hcnt;
                low_width   <= lcnt;
                period      <= period_sat;
                pulse_count <= pulse_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed stimulus on two pulse_meter instances (W=8/CW=16
// and W=4/CW=2) checked every cycle against a history-based model.
module tb_pulse_meter;

`ifdef PULSE_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clock, reset, signal;
    logic [7:0]  d8_hw, d8_lw, d8_per;
    logic [15:0] d8_pc;
    logic        d8_valid, d8_ovf, d8_busy;
    logic [3:0]  d4_hw, d4_lw, d4_per;
    logic [1:0]  d4_pc;
    logic        d4_valid, d4_ovf, d4_busy;

    pulse_meter #(.W(8), .CW(16)) dut8 (
        .clock(clock), .reset(reset), .signal(signal),
        .high_width(d8_hw), .low_width(d8_lw), .period(d8_per),
        .valid(d8_valid), .pulse_count(d8_pc), .overflow(d8_ovf), .busy(d8_busy)
    );

    pulse_meter #(.W(4), .CW(2)) dut4 (
        .clock(clock), .reset(reset), .signal(signal),
        .high_width(d4_hw), .low_width(d4_lw), .period(d4_per),
        .valid(d4_valid), .pulse_count(d4_pc), .overflow(d4_ovf), .busy(d4_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // model state: index 0 -> W=8/CW=16, index 1 -> W=4/CW=2
    int mx[2] = '{255, 15};
    int cw[2] = '{16, 2};
    int exp_hw[2], exp_lw[2], exp_per[2], exp_pc[2];
    bit exp_valid[2], exp_ovf[2];
    bit exp_busy;
    bit hist[$];
    bit d1, d2, sm;
    bit chk_en = 0;
    int cyc = 0;
    int vcnt8 = 0;
    int first_valid_cyc = -1;
    int fv_hw, fv_lw, fv_per, fv_pc;
    int n, rl, he, hl, st, hs, ls;
    bit meas;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Length of the run of equal samples ending at history index idx
    function automatic int run_back(input int idx);
        int r = 0;
        bit v = hist[idx];
        while (idx >= 0 && hist[idx] == v) begin
            r++;
            idx--;
        end
        return r;
    endfunction

    // Model: outputs follow from the sample history since reset
    always @(posedge clock) begin
        cyc++;
        if (!reset) begin
            hist.delete();
            d1 = 0;
            d2 = 0;
            for (int k = 0; k < 2; k++) begin
                exp_hw[k] = 0; exp_lw[k] = 0; exp_per[k] = 0; exp_pc[k] = 0;
                exp_valid[k] = 0; exp_ovf[k] = 0;
            end
            exp_busy = 0;
            chk_en = 1;
            vcnt8 = 0;
            first_valid_cyc = -1;
        end else begin
`ifdef PULSE_METER_SYNC_EN
            sm = d2; d2 = d1; d1 = signal;
`else
            sm = signal;
`endif
            hist.push_back(sm);
            n = hist.size();
            exp_valid[0] = 0;
            exp_valid[1] = 0;
            // a rise closes a pulse whose high run itself began after a low
            if (sm && (n < 2 || !hist[n-2]) && n >= 2) begin
                rl = run_back(n - 2);
                he = n - 2 - rl;
                if (he >= 0) begin
                    hl = run_back(he);
                    if (he - hl >= 0) begin
                        for (int k = 0; k < 2; k++) begin
                            hs = (hl > mx[k]) ? mx[k] : hl;
                            ls = (rl > mx[k]) ? mx[k] : rl;
                            exp_hw[k]  = hs;
                            exp_lw[k]  = ls;
                            exp_per[k] = (hs + ls > mx[k]) ? mx[k] : hs + ls;
                            exp_pc[k]  = (exp_pc[k] + 1) % (1 << cw[k]);
                            exp_valid[k] = 1;
                        end
                    end
                end
            end
            // overflow: a measured run has reached the counter maximum
            rl = run_back(n - 1);
            st = n - rl;
            meas = 0;
            if (sm) meas = (st >= 1);
            else if (st >= 1) begin
                hl = run_back(st - 1);
                meas = (st - 1 - hl >= 0);
            end
            for (int k = 0; k < 2; k++)
                if (meas && rl >= mx[k]) exp_ovf[k] = 1;
            if (sm && st >= 1) exp_busy = 1;
        end
    end

    // Compare process: every cycle once a reset has been applied
    always @(negedge clock) begin
        if (chk_en) begin
            chk("d8_high_width",  32'(d8_hw),    32'(exp_hw[0]));
            chk("d8_low_width",   32'(d8_lw),    32'(exp_lw[0]));
            chk("d8_period",      32'(d8_per),   32'(exp_per[0]));
            chk("d8_valid",       32'(d8_valid), 32'(exp_valid[0]));
            chk("d8_pulse_count", 32'(d8_pc),    32'(exp_pc[0]));
            chk("d8_overflow",    32'(d8_ovf),   32'(exp_ovf[0]));
            chk("d8_busy",        32'(d8_busy),  32'(exp_busy));
            chk("d4_high_width",  32'(d4_hw),    32'(exp_hw[1]));
            chk("d4_low_width",   32'(d4_lw),    32'(exp_lw[1]));
            chk("d4_period",      32'(d4_per),   32'(exp_per[1]));
            chk("d4_valid",       32'(d4_valid), 32'(exp_valid[1]));
            chk("d4_pulse_count", 32'(d4_pc),    32'(exp_pc[1]));
            chk("d4_overflow",    32'(d4_ovf),   32'(exp_ovf[1]));
            chk("d4_busy",        32'(d4_busy),  32'(exp_busy));
            if (d8_valid === 1'b1) begin
                vcnt8++;
                if (first_valid_cyc < 0) begin
                    first_valid_cyc = cyc;
                    fv_hw = 32'(d8_hw); fv_lw = 32'(d8_lw);
                    fv_per = 32'(d8_per); fv_pc = 32'(d8_pc);
                end
            end
        end
    end

    task automatic drive(input bit v, input int cycles);
        repeat (cycles) begin
            @(negedge clock);
            reset = 1'b1;
            signal = v;
        end
    endtask

    task automatic rst(input bit v, input int cycles, input bit toggle);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            reset = 1'b0;
            signal = toggle ? bit'(i % 2) : v;
        end
    endtask

    int t0;

    initial begin
        reset = 1'b0;
        signal = 1'b0;
        t0 = 0;

        // reset held with toggling input
        rst(1'b0, 3, 1'b1);
        #2;
        chk("rst_busy",  32'(d8_busy),  32'd0);
        chk("rst_valid", 32'(d8_valid), 32'd0);
        chk("rst_pc",    32'(d8_pc),    32'd0);
        chk("rst_hw",    32'(d8_hw),    32'd0);

        // 1-cycle high / 1-cycle low toggling
        drive(1'b0, 2);
        for (int i = 0; i < 10; i++) drive(bit'((i + 1) % 2), 1);
        drive(1'b0, 4);
        #2;
        chk("tog_pc",     32'(d8_pc),  32'd4);
        chk("tog_pc_wrap",32'(d4_pc),  32'd0);
        chk("tog_hw",     32'(d8_hw),  32'd1);
        chk("tog_lw",     32'(d8_lw),  32'd1);
        chk("tog_period", 32'(d8_per), 32'd2);
        chk("tog_vcnt",   32'(vcnt8),  32'd4);

        // 3 high / 5 low, four times
        rst(1'b0, 1, 1'b0);
        drive(1'b0, 2);
        for (int g = 0; g < 4; g++) begin
            drive(1'b1, 1);
            if (g == 1) t0 = cyc;
            drive(1'b1, 2);
            drive(1'b0, 5);
        end
        drive(1'b0, 4);
        #2;
        chk("p35_pc",      32'(d8_pc),  32'd3);
        chk("p35_pc_w4",   32'(d4_pc),  32'd3);
        chk("p35_hw",      32'(d8_hw),  32'd3);
        chk("p35_lw",      32'(d8_lw),  32'd5);
        chk("p35_period",  32'(d8_per), 32'd8);
        chk("p35_vcnt",    32'(vcnt8),  32'd3);
        chk("p35_latency", 32'(first_valid_cyc), 32'(t0 + 1 + LAT));

        // long high saturates the W=4 counter
        rst(1'b0, 1, 1'b0);
        drive(1'b0, 2);
        drive(1'b1, 20);
        drive(1'b0, 2);
        drive(1'b1, 1);
        drive(1'b0, 4);
        #2;
        chk("sat_d4_hw",     32'(d4_hw),  32'd15);
        chk("sat_d4_lw",     32'(d4_lw),  32'd2);
        chk("sat_d4_period", 32'(d4_per), 32'd15);
        chk("sat_d4_ovf",    32'(d4_ovf), 32'd1);
        chk("sat_d8_hw",     32'(d8_hw),  32'd20);
        chk("sat_d8_period", 32'(d8_per), 32'd22);
        chk("sat_d8_ovf",    32'(d8_ovf), 32'd0);
        drive(1'b0, 6);
        #2;
        chk("sat_d4_ovf_sticky", 32'(d4_ovf), 32'd1);
        chk("sat_vcnt",          32'(vcnt8),  32'd1);

        // reset pulse in the middle of a high phase
        rst(1'b0, 1, 1'b0);
        drive(1'b0, 2);
        drive(1'b1, 5);
        #2;
        chk("mid_busy_before", 32'(d8_busy), 32'd1);
        rst(1'b1, 1, 1'b0);
        drive(1'b1, 2);
        #2;
        chk("mid_busy_after", 32'(d8_busy), 32'd0);
        drive(1'b0, 2);
        for (int g = 0; g < 2; g++) begin
            drive(1'b1, 2);
            drive(1'b0, 2);
        end
        drive(1'b1, 1);
        drive(1'b0, 4);
        #2;
        chk("mid_first_hw",     32'(fv_hw),  32'd2);
        chk("mid_first_lw",     32'(fv_lw),  32'd2);
        chk("mid_first_period", 32'(fv_per), 32'd4);
        chk("mid_first_pc",     32'(fv_pc),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
